// File: rtl/cobs_stream_encoder_if.sv
// ---------------------------------------------------------------------------
// cobs_stream_encoder_if
//   Byte-wide AXI-Stream bundle used on both sides of the COBS framer.
//   tdata  : 8-bit payload byte
//   tvalid : source has a byte
//   tready : sink accepts the byte
//   tlast  : byte ends the frame
//   master : drives tdata/tvalid/tlast, samples tready
//   slave  : samples tdata/tvalid/tlast, drives tready
// ---------------------------------------------------------------------------
interface cobs_stream_encoder_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/cobs_stream_encoder.sv
// ---------------------------------------------------------------------------
// cobs_stream_encoder
//   Encodes each tlast-delimited byte frame into COBS form, optionally followed
//   by a 0x00 delimiter. One block buffer; input stalls while a block drains.
// Ports
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   s_axis         : raw frame bytes in (slave)
//   m_axis         : encoded bytes out (master), tlast on final byte of frame
//   busy           : first byte of a frame accepted, final byte not yet sent
//   frames_encoded : completed output frames, wraps
// ---------------------------------------------------------------------------
module cobs_stream_encoder #(
    parameter int MAX_RUN        = 254,
    parameter int EMIT_DELIMITER = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cobs_stream_encoder_if.slave     s_axis,
    cobs_stream_encoder_if.master    m_axis,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     frames_encoded
);

    localparam int CW    = $clog2(MAX_RUN + 1);
    localparam bit DELIM = (EMIT_DELIMITER != 0);

    typedef enum logic [1:0] {FILL, EMIT_CODE, EMIT_DATA, EMIT_DELIM} state_t;

    state_t               r_state;
    logic [7:0]           r_buf [MAX_RUN];
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        r_rd;
    logic                 r_fe;
    logic                 r_tail;
    logic                 r_s_ready;
    logic                 r_m_tvalid;
    logic [7:0]           r_m_tdata;
    logic                 r_m_tlast;
    logic                 r_busy;
    logic [CNT_WIDTH-1:0] r_frames;

    logic                 w_s_hs;
    logic                 w_m_hs;
    logic                 w_zero;
    logic                 w_full;
    logic                 w_close;
    logic                 w_tail;
    logic                 w_blk_done;
    logic [CW-1:0]        w_n;
    logic [CW-1:0]        w_stored;
    logic [7:0]           w_code;

    assign s_axis.tready  = r_s_ready;
    assign m_axis.tvalid  = r_m_tvalid;
    assign m_axis.tdata   = r_m_tdata;
    assign m_axis.tlast   = r_m_tlast;
    assign busy           = r_busy;
    assign frames_encoded = r_frames;

    always_comb begin
        w_s_hs     = s_axis.tvalid && r_s_ready;
        w_m_hs     = r_m_tvalid && m_axis.tready;
        w_zero     = (s_axis.tdata == 8'h00);
        w_n        = r_cnt + CW'(1);
        w_full     = !w_zero && (w_n == CW'(MAX_RUN));
        w_close    = w_zero || w_full || s_axis.tlast;
        // a zero byte is implied by the code, never stored
        w_stored   = w_zero ? r_cnt : w_n;
        w_code     = 8'(w_stored) + 8'd1;
        // frame ended right after a block boundary: an empty 0x01 block follows
        w_tail     = s_axis.tlast && (w_zero || w_full);
        w_blk_done = (r_rd == r_cnt);
    end

    // Block buffer: data only, no reset needed
    always_ff @(posedge clk) begin
        if (r_state == FILL && w_s_hs && !w_zero)
            r_buf[r_cnt] <= s_axis.tdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_fe       <= 1'b0;
            r_tail     <= 1'b0;
            r_s_ready  <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= 8'h00;
            r_m_tlast  <= 1'b0;
            r_busy     <= 1'b0;
            r_frames   <= '0;
        end else if (w_m_hs && r_m_tlast) begin
            // final byte of the encoded frame accepted
            r_state    <= FILL;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_s_ready  <= 1'b1;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_fe       <= 1'b0;
            r_tail     <= 1'b0;
            r_busy     <= 1'b0;
            r_frames   <= r_frames + CNT_WIDTH'(1);
        end else begin
            case (r_state)
                FILL: begin
                    r_s_ready <= 1'b1;
                    if (w_s_hs) begin
                        r_busy <= 1'b1;
                        if (w_close) begin
                            r_s_ready  <= 1'b0;
                            r_state    <= EMIT_CODE;
                            r_cnt      <= w_stored;
                            r_rd       <= '0;
                            r_fe       <= s_axis.tlast;
                            r_tail     <= w_tail;
                            r_m_tvalid <= 1'b1;
                            r_m_tdata  <= w_code;
                            r_m_tlast  <= !DELIM && s_axis.tlast && !w_tail &&
                                          (w_stored == CW'(0));
                        end else begin
                            r_cnt <= w_n;
                        end
                    end
                end
                EMIT_CODE, EMIT_DATA: begin
                    if (w_m_hs) begin
                        if (!w_blk_done) begin
                            r_state   <= EMIT_DATA;
                            r_m_tdata <= r_buf[r_rd];
                            r_rd      <= r_rd + CW'(1);
                            r_m_tlast <= !DELIM && r_fe && !r_tail &&
                                         ((r_rd + CW'(1)) == r_cnt);
                        end else if (r_tail) begin
                            // reuse EMIT_CODE with an empty block for the 0x01 tail
                            r_tail    <= 1'b0;
                            r_cnt     <= '0;
                            r_rd      <= '0;
                            r_state   <= EMIT_CODE;
                            r_m_tdata <= 8'h01;
                            r_m_tlast <= !DELIM;
                        end else if (r_fe) begin
                            r_state   <= EMIT_DELIM;
                            r_m_tdata <= 8'h00;
                            r_m_tlast <= 1'b1;
                        end else begin
                            r_state    <= FILL;
                            r_m_tvalid <= 1'b0;
                            r_s_ready  <= 1'b1;
                            r_cnt      <= '0;
                            r_rd       <= '0;
                        end
                    end
                end
                default: ;  // EMIT_DELIM only leaves through the final-byte branch
            endcase
        end
    end

endmodule

// File: tb/tb_cobs_stream_encoder.sv
// Bench for cobs_stream_encoder: default instance (MAX_RUN=254, delimiter on) and
// a small instance (MAX_RUN=4, no delimiter) share one driver; sel picks the target.
module tb_cobs_stream_encoder;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [7:0]  drv_data = 8'h00;
    logic        drv_valid = 1'b0;
    logic        drv_last = 1'b0;
    logic        mrdy = 1'b0;
    int          rmode = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          fcnt[2] = '{0, 0};

    logic        busy0, busy1;
    logic [15:0] fr0, fr1;
    logic        o_valid, o_last, s_ready_o, busy_o;
    logic [7:0]  o_data;
    logic [15:0] frames_o;

    always #5 clk = ~clk;

    cobs_stream_encoder_if s0 ();
    cobs_stream_encoder_if m0 ();
    cobs_stream_encoder_if s1 ();
    cobs_stream_encoder_if m1 ();

    assign s0.tdata  = drv_data;
    assign s0.tvalid = drv_valid & ~sel;
    assign s0.tlast  = drv_last;
    assign s1.tdata  = drv_data;
    assign s1.tvalid = drv_valid & sel;
    assign s1.tlast  = drv_last;
    assign m0.tready = mrdy;
    assign m1.tready = mrdy;

    assign o_valid   = sel ? m1.tvalid : m0.tvalid;
    assign o_data    = sel ? m1.tdata  : m0.tdata;
    assign o_last    = sel ? m1.tlast  : m0.tlast;
    assign s_ready_o = sel ? s1.tready : s0.tready;
    assign busy_o    = sel ? busy1 : busy0;
    assign frames_o  = sel ? fr1 : fr0;

    cobs_stream_encoder u_dut0 (
        .clk(clk), .rst_n(rst_n), .s_axis(s0), .m_axis(m0),
        .busy(busy0), .frames_encoded(fr0)
    );

    cobs_stream_encoder #(.MAX_RUN(4), .EMIT_DELIMITER(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis(s1), .m_axis(m1),
        .busy(busy1), .frames_encoded(fr1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference COBS: blocks of up to maxrun non-zero bytes; a zero or a full run
    // closes a block; if the frame ends right at a closed block an empty block follows.
    function automatic bq_t cobs_ref(input bq_t fr, input int maxrun, input bit delim);
        bq_t out, cur;
        bit  closed;
        out = {};
        cur = {};
        closed = 1'b0;
        foreach (fr[i]) begin
            closed = 1'b0;
            if (fr[i] == 8'h00) begin
                out.push_back(8'(cur.size() + 1));
                foreach (cur[j]) out.push_back(cur[j]);
                cur = {};
                closed = 1'b1;
            end else begin
                cur.push_back(fr[i]);
                if (cur.size() == maxrun) begin
                    out.push_back(8'(maxrun + 1));
                    foreach (cur[j]) out.push_back(cur[j]);
                    cur = {};
                    closed = 1'b1;
                end
            end
        end
        if (closed) out.push_back(8'h01);
        else begin
            out.push_back(8'(cur.size() + 1));
            foreach (cur[j]) out.push_back(cur[j]);
        end
        if (delim) out.push_back(8'h00);
        return out;
    endfunction

    task automatic drive(input bq_t fr);
        int i = 0;
        int guard = 0;
        while (i < fr.size() && guard < 20000) begin
            @(negedge clk);
            drv_valid = ($urandom_range(3) != 0);
            drv_data  = fr[i];
            drv_last  = (i == fr.size() - 1);
            if (drv_valid && s_ready_o) i++;
            guard++;
        end
        if (i < fr.size()) chk("drv_timeout", 32'(i), 32'(fr.size()));
        @(negedge clk);
        drv_valid = 1'b0;
        drv_last  = 1'b0;
    endtask

    task automatic collect(output bq_t got);
        int         guard = 0;
        bit         done = 1'b0;
        bit         stall = 1'b0;
        bit         seen = 1'b0;
        logic [7:0] hd = 8'h00;
        logic       hl = 1'b0;
        got = {};
        while (!done && guard < 40000) begin
            @(negedge clk);
            guard++;
            if (stall) begin
                chk("hold_vld", 32'(o_valid), 32'd1);
                chk("hold_data", 32'(o_data), 32'(hd));
                chk("hold_last", 32'(o_last), 32'(hl));
            end
            if (o_valid) begin
                chk("s_rdy_low", 32'(s_ready_o), 32'd0);
                if (!seen) chk("busy_on", 32'(busy_o), 32'd1);
                seen = 1'b1;
            end
            case (rmode)
                0:       mrdy = 1'b1;
                1:       mrdy = guard[0];
                default: mrdy = 1'($urandom_range(1));
            endcase
            if (o_valid && mrdy) begin
                got.push_back(o_data);
                if (o_last) done = 1'b1;
            end
            stall = o_valid && !mrdy;
            hd = o_data;
            hl = o_last;
        end
        if (!done) chk("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_frame(input bq_t fr);
        bq_t exp, got;
        int  n;
        exp = cobs_ref(fr, sel ? 4 : 254, !sel);
        fork
            drive(fr);
            collect(got);
        join
        chk("len", 32'(got.size()), 32'(exp.size()));
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) chk($sformatf("byte%0d", i), 32'(got[i]), 32'(exp[i]));
        fcnt[sel]++;
        @(negedge clk);
        chk("busy_off", 32'(busy_o), 32'd0);
        chk("frames", 32'(frames_o), 32'(fcnt[sel]));
    endtask

    function automatic bq_t rnd_frame(input int len, input int zpct);
        bq_t f;
        f = {};
        for (int i = 0; i < len; i++)
            f.push_back(($urandom_range(99) < zpct) ? 8'h00 : 8'($urandom_range(255, 1)));
        return f;
    endfunction

    initial begin
        bq_t f;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_vld0", 32'(m0.tvalid), 32'd0);
        chk("rst_rdy0", 32'(s0.tready), 32'd0);
        chk("rst_busy0", 32'(busy0), 32'd0);
        chk("rst_frames0", 32'(fr0), 32'd0);
        chk("rst_vld1", 32'(m1.tvalid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", 32'(s0.tready), 32'd1);

        // directed frames, default instance
        sel = 1'b0;
        rmode = 0;
        run_frame('{8'h69, 8'h6A, 8'h6B});
        run_frame('{8'h11, 8'h00, 8'h22});
        run_frame('{8'h00});
        f = {};
        for (int i = 1; i <= 254; i++) f.push_back(8'(i));
        run_frame(f);
        f.push_back(8'h07);
        run_frame(f);
        f = {};
        for (int i = 1; i <= 254; i++) f.push_back(8'(i));
        f.push_back(8'h00);
        run_frame(f);
        run_frame('{8'h00, 8'h00, 8'h00});

        // stall pattern on the first example
        rmode = 1;
        run_frame('{8'h69, 8'h6A, 8'h6B});

        // random frames with random backpressure
        rmode = 2;
        for (int k = 0; k < 16; k++)
            run_frame(rnd_frame($urandom_range(600, 1), (k % 3 == 0) ? 30 : 2));

        // small instance: MAX_RUN=4, no delimiter
        sel = 1'b1;
        rmode = 0;
        run_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        run_frame('{8'h01, 8'h02, 8'h03, 8'h04});
        run_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h00});
        run_frame('{8'h00});
        rmode = 2;
        for (int k = 0; k < 20; k++)
            run_frame(rnd_frame($urandom_range(20, 1), 25));

        // reset pulsed while an encoded byte is stalled
        sel = 1'b0;
        mrdy = 1'b0;
        drive('{8'h01, 8'h02, 8'h03});
        @(negedge clk);
        chk("stall_vld", 32'(m0.tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(m0.tvalid), 32'd0);
        chk("mid_rst_tdata", 32'(m0.tdata), 32'd0);
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        chk("mid_rst_rdy", 32'(s0.tready), 32'd0);
        fcnt[0] = 0;
        fcnt[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rmode = 0;
        run_frame('{8'h69, 8'h6A, 8'h6B});
        sel = 1'b1;
        run_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
